hm_top_core: RTL and testbench
==============================

Name: hm_top_core

Overview:
- Host-memory reader. Software programs a 64-bit host bus address and starts a fetch through CSRs.
- The block issues one PCIe Memory Read TLP on the Xilinx 64-bit TRN transmit interface.
- It captures the matching CplD payload from the TRN receive interface into a local 2-bank dual-read buffer.
- The buffer is readable over a 32-bit Wishbone slave and a direct 64-bit hm_addr/hm_data port. Sits between the PCIe endpoint core and the SoC CSR/Wishbone buses.

Parameters:
- csr_addr, 4'h0, CSR page select, compared with csr_a[13:10].
- depth_log2, 4, log2 of rows per bank. Buffer = 2^depth_log2 × 64 bits; request = 2^(depth_log2+1) DW (default 32 DW, 128 B).
- req_id, 16'h0000, Requester ID placed in MRd headers.

Ports:
- sys_clk in 1: single clock for all logic. trn_clk is required to be the same clock and is not used internally.
- sys_rst in 1: reset, synchronous, active-high.
- csr_a in 14: CSR address.
- csr_we in 1: CSR write strobe.
- csr_di in 32: CSR write data.
- csr_do out 32: CSR read data.
- wb_adr_i in 32 / wb_dat_i in 32 / wb_sel_i in 4 / wb_stb_i in 1 / wb_cyc_i in 1 / wb_we_i in 1: Wishbone slave inputs.
- wb_dat_o out 32 / wb_ack_o out 1: Wishbone slave outputs.
- hm_addr in 64: byte address into buffer. hm_data out 64: qword read data.
- trn_clk in 1; trn_reset_n in 1; trn_lnk_up_n in 1; trn_tbuf_av in 6; trn_tcfg_req_n in 1; trn_terr_drop_n in 1; trn_tdst_rdy_n in 1: TRN status and tx flow control.
- trn_rd in 64; trn_rrem_n in 8; trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n in 1; trn_rbar_hit_n in 7: TRN receive.
- trn_td out 64; trn_trem_n out 8; trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n, trn_terrfwd_n, trn_tcfg_gnt_n, trn_tstr_n, trn_rdst_rdy_n, trn_rnp_ok_n out 1: TRN transmit/control.

Behaviour:
- Reset condition: sys_rst=1 or trn_reset_n=0, sampled on sys_clk. Effects:
  - Tx FSM → IDLE; busy=0, done=0.
  - Address registers = 0; csr_do=0; wb_ack_o=0.
  - trn_tsof_n=trn_teof_n=trn_tsrc_rdy_n=1.
  - Buffer contents not cleared.
- Constant outputs: trn_tsrc_dsc_n=1, trn_terrfwd_n=1, trn_tstr_n=1, trn_tcfg_gnt_n=0, trn_rdst_rdy_n=0, trn_rnp_ok_n=0.
- CSRs are selected when csr_a[13:10]==csr_addr; register index is csr_a[1:0]. Reads are registered (1 cycle); csr_do=0 when not selected.
  - 0 CTRL:
    - Write bit0=1: start. Ignored when busy=1.
    - Write bit1=1: clear done.
    - Read: bit0 busy, bit1 done, other bits 0.
  - 1 ADDRESS_LOW: R/W. Bits [6:0] are stored but treated as 0 in the request (request is 128 B aligned).
  - 2 ADDRESS_HIGH: R/W.
  - 3: reads 0, writes ignored.
- Tx FSM states: IDLE → WAIT → BEAT0 → BEAT1 → RX.
  - start: IDLE→WAIT, busy=1, received-DW counter cleared.
  - WAIT→BEAT0 when trn_lnk_up_n=0.
  - Each beat is held, with trn_tsrc_rdy_n=0, until a cycle with trn_tdst_rdy_n=0, then advances.
- MRd header:
  - DW0: fmt=00 (3DW) if ADDRESS_HIGH==0, else 01 (4DW); type=00000; TC/attr=0; length=2^(depth_log2+1).
  - DW1: {req_id, tag 8'h00, lastBE 4'hF, firstBE 4'hF}.
- Beat layout:
  - BEAT0: trn_td={DW0,DW1}, tsof_n=0, trem_n=8'h00.
  - BEAT1 (3DW): trn_td={addr_low_aligned, 32'h0}, teof_n=0, trem_n=8'h0F.
  - BEAT1 (4DW): trn_td={ADDRESS_HIGH, addr_low_aligned}, teof_n=0, trem_n=8'h00.
- Rx parser (receive is always enabled):
  - A beat counts only when trn_rsrc_rdy_n=0. On SOF, trn_rd[63:32] is header DW0.
  - Packet is accepted only if DW0[30:24]==7'h4A (CplD), trn_rbar_hit_n is ignored, and on beat 2 the tag trn_rd[47:40]==8'h00.
  - Non-matching packets are dropped until EOF, with no buffer writes.
  - Base DW index = lower address trn_rd[38:34] of beat 2. Beat 2 low dword = payload DW0 → index base.
  - Subsequent beats: upper dword, then lower dword, at consecutive indices. Lower dword is skipped on EOF beat when trn_rrem_n=8'h0F.
  - Index wraps modulo 2^(depth_log2+1).
  - DW index d is written to bank d[0], row d[depth_log2:1].
  - Each written DW increments the counter. When the counter reaches the request length: busy=0, done=1, FSM → IDLE.
  - trn_rsrc_dsc_n and trn_rerrfwd_n are ignored.
- Wishbone:
  - Read-only. wb_ack_o pulses 1 cycle, one cycle after the first cyc&stb cycle, and is not re-asserted in the following cycle.
  - wb_dat_o = DW at index wb_adr_i[depth_log2+2:2], i.e. bank wb_adr_i[2], row wb_adr_i[depth_log2+2:3].
  - Writes are acked and ignored.
- hm_data is registered, 1 cycle after hm_addr: {bank1[row], bank0[row]} with row = hm_addr[depth_log2+2:3].
- trn_reset_n=0 mid-transfer aborts to IDLE; partially written data remains in the buffer.

Test Plan:
- Write ADDRESS_LOW=0xcacacaca and ADDRESS_HIGH=0, read both back → 0xcacacaca and 0x00000000.
- Link up, write CTRL=3, hold trn_tdst_rdy_n=0 → beat0 {0x00000020, 0x000000FF}, beat1 {0xcacaca80, x} with trem_n=0x0F, tsof/teof correct. CTRL reads busy=1.
- Inject a TLP with DW0[30:24]≠0x4A → no buffer change; busy stays 1.
- CplD of 32 DW, lower address 0, payload DWi=i+1 → done=1, busy=0. Wishbone read of address 0x4 returns 0x00000002 with a 1-cycle ack.
- Set hm_addr=0x8 → hm_data=0x0000000400000003 on the next cycle.
- Two split completions (16 DW at lower address 0x00, 16 DW at 0x40) → done only after the second completion; data contiguous in the buffer.

Source files
------------

// File: rtl/hm_top_core.sv
// Host-memory reader: issues one PCIe MRd on TRN tx, captures the matching CplD
// payload into a 2-bank buffer readable over Wishbone and a direct qword port.
module hm_top_core #(
  parameter logic [3:0]  csr_addr   = 4'h0,
  parameter int          depth_log2 = 4,
  parameter logic [15:0] req_id     = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [63:0] hm_addr,
  output logic [63:0] hm_data,
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic        trn_lnk_up_n,
  input  logic [5:0]  trn_tbuf_av,
  input  logic        trn_tcfg_req_n,
  input  logic        trn_terr_drop_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rsrc_dsc_n,
  input  logic        trn_rerrfwd_n,
  input  logic [6:0]  trn_rbar_hit_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  output logic        trn_terrfwd_n,
  output logic        trn_tcfg_gnt_n,
  output logic        trn_tstr_n,
  output logic        trn_rdst_rdy_n,
  output logic        trn_rnp_ok_n
);

  localparam int ROWS  = 1 << depth_log2;
  localparam int IDX_W = depth_log2 + 1;
  localparam int LEN   = 1 << IDX_W;
  localparam logic [9:0]       LEN10   = 10'(LEN);
  localparam logic [IDX_W:0]   LEN_C   = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_TWO = {{(IDX_W-2){1'b0}}, 2'b10};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_RX    = 3'd4
  } tx_state_t;

  logic rst_s;
  logic unused_ok;

  assign rst_s = sys_rst | ~trn_reset_n;

  assign trn_tsrc_dsc_n = 1'b1;
  assign trn_terrfwd_n  = 1'b1;
  assign trn_tstr_n     = 1'b1;
  assign trn_tcfg_gnt_n = 1'b0;
  assign trn_rdst_rdy_n = 1'b0;
  assign trn_rnp_ok_n   = 1'b0;

  assign unused_ok = &{1'b0, trn_clk, trn_tbuf_av, trn_tcfg_req_n, trn_terr_drop_n,
                       trn_rsrc_dsc_n, trn_rerrfwd_n, trn_rbar_hit_n, csr_a, wb_adr_i,
                       wb_dat_i, wb_sel_i, wb_we_i, hm_addr};

  tx_state_t        state_r, state_nx_s;
  logic [31:0]      addr_lo_r, addr_hi_r;
  logic             done_r;
  logic [IDX_W:0]   cnt_r, cnt_sum_s;
  logic [1:0]       inc_s;
  logic             busy_s, finish_s, start_s, clr_done_s;
  logic             csr_sel_s, csr_wr_s;
  logic [1:0]       csr_idx_s;

  assign csr_sel_s  = (csr_a[13:10] == csr_addr);
  assign csr_wr_s   = csr_sel_s & csr_we;
  assign csr_idx_s  = csr_a[1:0];
  assign busy_s     = (state_r != ST_IDLE);
  assign start_s    = csr_wr_s & (csr_idx_s == 2'd0) & csr_di[0] & ~busy_s;
  assign clr_done_s = csr_wr_s & (csr_idx_s == 2'd0) & csr_di[1];
  assign cnt_sum_s  = cnt_r + {{(IDX_W-1){1'b0}}, inc_s};
  assign finish_s   = busy_s & (cnt_sum_s >= LEN_C);

  // CSR registers, completion accounting and registered CSR read data
  always_ff @(posedge sys_clk) begin
    if (rst_s) begin
      addr_lo_r <= 32'h0;
      addr_hi_r <= 32'h0;
      done_r    <= 1'b0;
      cnt_r     <= '0;
      csr_do    <= 32'h0;
    end else begin
      if (csr_wr_s && csr_idx_s == 2'd1) addr_lo_r <= csr_di;
      if (csr_wr_s && csr_idx_s == 2'd2) addr_hi_r <= csr_di;
      if (finish_s) done_r <= 1'b1;
      else if (clr_done_s) done_r <= 1'b0;
      if (start_s) cnt_r <= '0;
      else if (busy_s) cnt_r <= cnt_sum_s;
      if (csr_sel_s) begin
        case (csr_idx_s)
          2'd0:    csr_do <= {30'h0, done_r, busy_s};
          2'd1:    csr_do <= addr_lo_r;
          2'd2:    csr_do <= addr_hi_r;
          default: csr_do <= 32'h0;
        endcase
      end else begin
        csr_do <= 32'h0;
      end
    end
  end

  logic        is4dw_s;
  logic [31:0] addr_lo_al_s, dw0_s, dw1_s;
  logic [63:0] td_nx_s;
  logic [7:0]  trem_nx_s;

  assign is4dw_s      = (addr_hi_r != 32'h0);
  assign addr_lo_al_s = {addr_lo_r[31:7], 7'h00};
  assign dw0_s        = {2'b00, is4dw_s, 5'b00000, 14'h0000, LEN10};
  assign dw1_s        = {req_id, 8'h00, 4'hF, 4'hF};

  // Tx next state; a finished completion returns to idle from any state
  always_comb begin
    state_nx_s = state_r;
    if (finish_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nx_s = start_s ? ST_WAIT : ST_IDLE;
        ST_WAIT:  state_nx_s = trn_lnk_up_n ? ST_WAIT : ST_BEAT0;
        ST_BEAT0: state_nx_s = trn_tdst_rdy_n ? ST_BEAT0 : ST_BEAT1;
        ST_BEAT1: state_nx_s = trn_tdst_rdy_n ? ST_BEAT1 : ST_RX;
        ST_RX:    state_nx_s = ST_RX;
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Beat contents for the state being entered, so tx outputs are true flops
  always_comb begin
    td_nx_s   = 64'h0;
    trem_nx_s = 8'h00;
    case (state_nx_s)
      ST_BEAT0: td_nx_s = {dw0_s, dw1_s};
      ST_BEAT1: begin
        if (is4dw_s) begin
          td_nx_s = {addr_hi_r, addr_lo_al_s};
        end else begin
          td_nx_s   = {addr_lo_al_s, 32'h0};
          trem_nx_s = 8'h0F;
        end
      end
      default: td_nx_s = 64'h0;
    endcase
  end

  // Tx state register and registered TRN transmit outputs
  always_ff @(posedge sys_clk) begin
    if (rst_s) begin
      state_r        <= ST_IDLE;
      trn_td         <= 64'h0;
      trn_trem_n     <= 8'h00;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
    end else begin
      state_r        <= state_nx_s;
      trn_td         <= td_nx_s;
      trn_trem_n     <= trem_nx_s;
      trn_tsof_n     <= (state_nx_s != ST_BEAT0);
      trn_teof_n     <= (state_nx_s != ST_BEAT1);
      trn_tsrc_rdy_n <= !(state_nx_s == ST_BEAT0 || state_nx_s == ST_BEAT1);
    end
  end

  logic             rx_in_r, rx_second_r, rx_ok_r, rx_hdr_ok_r;
  logic [IDX_W-1:0] rx_idx_r, idx_nx_s, base_s;
  logic             rx_beat_s, lo_skip_s, accept2_s;
  logic             pa_en_s, pb_en_s;
  logic [IDX_W-1:0] pa_idx_s, pb_idx_s;
  logic [31:0]      pa_dat_s, pb_dat_s;

  assign rx_beat_s = ~trn_rsrc_rdy_n;
  assign lo_skip_s = ~trn_reof_n & (trn_rrem_n == 8'h0F);
  assign accept2_s = rx_hdr_ok_r & (trn_rd[47:40] == 8'h00);
  assign base_s    = IDX_W'(trn_rd[38:34]);

  // Payload dword write ports: A carries the upper dword, B the lower one
  always_comb begin
    pa_en_s  = 1'b0;
    pa_idx_s = rx_idx_r;
    pa_dat_s = trn_rd[63:32];
    pb_en_s  = 1'b0;
    pb_idx_s = rx_idx_r + IDX_ONE;
    pb_dat_s = trn_rd[31:0];
    inc_s    = 2'd0;
    idx_nx_s = rx_idx_r;
    if (rx_beat_s && trn_rsof_n && rx_in_r && rx_second_r) begin
      pb_idx_s = base_s;
      idx_nx_s = base_s + IDX_ONE;
      if (accept2_s && !lo_skip_s) begin
        pb_en_s = 1'b1;
        inc_s   = 2'd1;
      end else begin
        pb_en_s = 1'b0;
      end
    end else if (rx_beat_s && trn_rsof_n && rx_in_r && rx_ok_r) begin
      pa_en_s  = 1'b1;
      pb_en_s  = ~lo_skip_s;
      inc_s    = lo_skip_s ? 2'd1 : 2'd2;
      idx_nx_s = rx_idx_r + (lo_skip_s ? IDX_ONE : IDX_TWO);
    end else begin
      inc_s = 2'd0;
    end
  end

  // Receive packet parser: header check on SOF, tag check on the second beat
  always_ff @(posedge sys_clk) begin
    if (rst_s) begin
      rx_in_r     <= 1'b0;
      rx_second_r <= 1'b0;
      rx_ok_r     <= 1'b0;
      rx_hdr_ok_r <= 1'b0;
      rx_idx_r    <= '0;
    end else if (rx_beat_s) begin
      if (!trn_rsof_n) begin
        rx_in_r     <= trn_reof_n;
        rx_second_r <= trn_reof_n;
        rx_ok_r     <= 1'b0;
        rx_hdr_ok_r <= (trn_rd[62:56] == 7'h4A);
      end else if (rx_in_r) begin
        rx_idx_r    <= idx_nx_s;
        rx_second_r <= 1'b0;
        if (!trn_reof_n) begin
          rx_in_r <= 1'b0;
          rx_ok_r <= 1'b0;
        end else if (rx_second_r) begin
          rx_ok_r <= accept2_s;
        end
      end
    end
  end

  logic [31:0]            bank0_r [ROWS];
  logic [31:0]            bank1_r [ROWS];
  logic                   b0_en_s, b1_en_s;
  logic [depth_log2-1:0]  b0_row_s, b1_row_s;
  logic [31:0]            b0_dat_s, b1_dat_s;

  // Route the two ports to banks; consecutive indices never share a bank
  always_comb begin
    b0_en_s  = 1'b0;
    b0_row_s = pa_idx_s[IDX_W-1:1];
    b0_dat_s = pa_dat_s;
    b1_en_s  = 1'b0;
    b1_row_s = pa_idx_s[IDX_W-1:1];
    b1_dat_s = pa_dat_s;
    if (pa_en_s && !pa_idx_s[0]) begin
      b0_en_s = 1'b1;
    end else if (pb_en_s && !pb_idx_s[0]) begin
      b0_en_s  = 1'b1;
      b0_row_s = pb_idx_s[IDX_W-1:1];
      b0_dat_s = pb_dat_s;
    end else begin
      b0_en_s = 1'b0;
    end
    if (pa_en_s && pa_idx_s[0]) begin
      b1_en_s = 1'b1;
    end else if (pb_en_s && pb_idx_s[0]) begin
      b1_en_s  = 1'b1;
      b1_row_s = pb_idx_s[IDX_W-1:1];
      b1_dat_s = pb_dat_s;
    end else begin
      b1_en_s = 1'b0;
    end
  end

  // Buffer storage; contents survive reset
  always_ff @(posedge sys_clk) begin
    if (b0_en_s) bank0_r[b0_row_s] <= b0_dat_s;
    if (b1_en_s) bank1_r[b1_row_s] <= b1_dat_s;
  end

  logic [depth_log2-1:0] wb_row_s, hm_row_s;
  logic                  wb_req_s;

  assign wb_row_s = wb_adr_i[depth_log2+2:3];
  assign hm_row_s = hm_addr[depth_log2+2:3];
  assign wb_req_s = wb_cyc_i & wb_stb_i & ~wb_ack_o;

  // Read ports: single-pulse Wishbone ack and the direct qword port
  always_ff @(posedge sys_clk) begin
    if (rst_s) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0;
      hm_data  <= 64'h0;
    end else begin
      wb_ack_o <= wb_req_s;
      if (wb_req_s) wb_dat_o <= wb_adr_i[2] ? bank1_r[wb_row_s] : bank0_r[wb_row_s];
      hm_data <= {bank1_r[hm_row_s], bank0_r[hm_row_s]};
    end
  end

endmodule

// File: tb/tb_hm_top_core.sv
// Bench for hm_top_core: scoreboarded MRd beats and buffer reads against a
// bench-side buffer model fed by injected completions.
module tb_hm_top_core;

  logic        clk = 1'b0;
  logic        sys_rst, trn_reset_n, trn_lnk_up_n, trn_tdst_rdy_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di, csr_do;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [63:0] hm_addr, hm_data;
  logic [63:0] trn_rd, trn_td;
  logic [7:0]  trn_rrem_n, trn_trem_n;
  logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n, trn_terrfwd_n;
  logic        trn_tcfg_gnt_n, trn_tstr_n, trn_rdst_rdy_n, trn_rnp_ok_n;

  always #5 clk = ~clk;

  hm_top_core dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .hm_addr(hm_addr), .hm_data(hm_data),
    .trn_clk(clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
    .trn_tbuf_av(6'h3F), .trn_tcfg_req_n(1'b1), .trn_terr_drop_n(1'b1),
    .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rsrc_dsc_n(1'b1), .trn_rerrfwd_n(1'b1),
    .trn_rbar_hit_n(7'h7E),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
    .trn_terrfwd_n(trn_terrfwd_n), .trn_tcfg_gnt_n(trn_tcfg_gnt_n), .trn_tstr_n(trn_tstr_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rnp_ok_n(trn_rnp_ok_n)
  );

  typedef struct packed {
    logic [63:0] td;
    logic [7:0]  trem;
    logic        sof;
    logic        eof;
  } tx_beat_t;

  tx_beat_t    tx_q[$];
  tx_beat_t    mon_e;
  logic [63:0] rd_q[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepted tx beats are popped against the expected MRd beats
  always @(negedge clk) begin
    if (trn_tsrc_rdy_n === 1'b0 && trn_tdst_rdy_n === 1'b0) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected_beat", 64'(tx_q.size()), 64'd1);
      end else begin
        mon_e = tx_q.pop_front();
        check("tx_td", trn_td, mon_e.td);
        check("tx_ctl", {trn_trem_n, trn_tsof_n, trn_teof_n}, {mon_e.trem, mon_e.sof, mon_e.eof});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mrd(input logic [31:0] hi, input logic [31:0] lo);
    tx_beat_t    b;
    logic        is4;
    logic [31:0] al;
    is4    = (hi != 32'h0);
    al     = {lo[31:7], 7'h00};
    b.td   = {(is4 ? 32'h2000_0020 : 32'h0000_0020), 32'h0000_00FF};
    b.trem = 8'h00;
    b.sof  = 1'b0;
    b.eof  = 1'b1;
    tx_q.push_back(b);
    b.td   = is4 ? {hi, al} : {al, 32'h0};
    b.trem = is4 ? 8'h00 : 8'h0F;
    b.sof  = 1'b1;
    b.eof  = 1'b0;
    tx_q.push_back(b);
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
    csr_a  = 14'h3C00;
  endtask

  task automatic check_csr(input string tag, input logic [13:0] a, input logic [31:0] exp);
    csr_a  = a;
    csr_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check(tag, {32'h0, csr_do}, {32'h0, exp});
    csr_a = 14'h3C00;
  endtask

  task automatic drain_tx(input string tag, input bit rand_rdy);
    int n;
    n = 0;
    while (tx_q.size() > 0 && n < 200) begin
      trn_tdst_rdy_n = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
    end
    trn_tdst_rdy_n = 1'b0;
    check(tag, 64'(tx_q.size()), 64'd0);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic sof, input logic eof, input logic [7:0] rem);
    if ($urandom_range(0, 3) == 0) begin
      trn_rsrc_rdy_n = 1'b1;
      trn_rd         = {$urandom, $urandom};
      trn_rsof_n     = 1'($urandom_range(0, 1));
      trn_reof_n     = 1'($urandom_range(0, 1));
      tick();
    end
    trn_rd         = d;
    trn_rsof_n     = ~sof;
    trn_reof_n     = ~eof;
    trn_rrem_n     = rem;
    trn_rsrc_rdy_n = 1'b0;
    tick();
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rrem_n     = 8'h00;
  endtask

  task automatic send_pkt(input logic [6:0] typ, input logic [7:0] tag, input logic [6:0] laddr,
                          input int ndw, input logic [31:0] v0, input bit upd);
    int rest;
    int k;
    rest = ndw - 1;
    k    = 1;
    send_beat({1'b0, typ, 14'h0, 10'(ndw), 32'h0100_0000}, 1'b1, 1'b0, 8'h00);
    send_beat({16'h0000, tag, 1'b0, laddr, v0}, 1'b0, (rest == 0), 8'h00);
    while (rest > 0) begin
      if (rest >= 2) begin
        send_beat({32'(v0 + k), 32'(v0 + k + 1)}, 1'b0, (rest == 2), 8'h00);
        rest -= 2;
        k    += 2;
      end else begin
        send_beat({32'(v0 + k), 32'hDEAD_BEEF}, 1'b0, 1'b1, 8'h0F);
        rest -= 1;
      end
    end
    if (upd) begin
      for (int i = 0; i < ndw; i++) model[(int'(laddr[6:2]) + i) % 32] = 32'(v0 + i);
    end
    tick();
  endtask

  task automatic wb_access(input string tag, input logic [31:0] adr, input logic we, input logic [31:0] exp);
    int          n;
    logic [63:0] e;
    if (!we) rd_q.push_back({32'h0, exp});
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = 32'hFFFF_FFFF;
    wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (!wb_ack_o && n < 8) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_ack_latency"}, 64'(n), 64'd0);
    if (!we) begin
      e = rd_q.pop_front();
      if (wb_ack_o) check(tag, {32'h0, wb_dat_o}, e);
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack_pulse"}, {63'h0, wb_ack_o}, 64'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    tick();
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) wb_access(tag, 32'(i * 4), 1'b0, model[i]);
  endtask

  task automatic hm_read(input string tag, input logic [63:0] a, input logic [63:0] exp);
    rd_q.push_back(exp);
    hm_addr = a;
    @(posedge clk);
    @(negedge clk);
    check(tag, hm_data, rd_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; trn_reset_n = 1'b1; trn_lnk_up_n = 1'b1; trn_tdst_rdy_n = 1'b0;
    csr_a = 14'h3C00; csr_we = 1'b0; csr_di = 32'h0;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; hm_addr = 64'h0;
    trn_rd = 64'h0; trn_rrem_n = 8'h00; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();

    @(negedge clk);
    check("rst_tx_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h7);
    check("rst_wb_ack", {63'h0, wb_ack_o}, 64'd0);
    check("rst_csr_do", {32'h0, csr_do}, 64'd0);
    check("const_outs", {58'h0, trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n,
                         trn_tcfg_gnt_n, trn_rdst_rdy_n, trn_rnp_ok_n}, 64'h38);
    check_csr("rst_ctrl", 14'h0000, 32'h0);
    check_csr("rst_addr_lo", 14'h0001, 32'h0);

    csr_write(14'h0001, 32'hcacacaca);
    csr_write(14'h0002, 32'h0000_0000);
    csr_write(14'h0003, 32'h1234_5678);
    check_csr("addr_lo_rb", 14'h0001, 32'hcacacaca);
    check_csr("addr_hi_rb", 14'h0002, 32'h0);
    check_csr("reg3_zero", 14'h0003, 32'h0);
    check_csr("csr_unselected", 14'h0401, 32'h0);

    // Start with the link down: nothing may go out until link up
    push_mrd(32'h0, 32'hcacacaca);
    csr_write(14'h0000, 32'h3);
    repeat (4) tick();
    @(negedge clk);
    check("wait_no_beat", {63'h0, trn_tsrc_rdy_n}, 64'd1);
    check_csr("busy_wait", 14'h0000, 32'h1);
    trn_lnk_up_n = 1'b0;
    drain_tx("tx_drain_3dw", 1'b0);
    check_csr("busy_after_mrd", 14'h0000, 32'h1);
    csr_write(14'h0000, 32'h1);
    repeat (6) tick();

    send_pkt(7'h0A, 8'h00, 7'h00, 32, 32'hBAD0_0000, 1'b0);
    check_csr("busy_after_bad_type", 14'h0000, 32'h1);

    send_pkt(7'h4A, 8'h00, 7'h00, 32, 32'h1, 1'b1);
    check_csr("done_after_cpld", 14'h0000, 32'h2);
    wb_access("wb_dw1", 32'h4, 1'b0, 32'h0000_0002);
    read_all("wb_full");
    hm_read("hm_addr8", 64'h8, 64'h0000_0004_0000_0003);
    hm_read("hm_addr_offset", 64'h0C, 64'h0000_0004_0000_0003);
    hm_read("hm_addr_high", 64'hFFFF_0000_0000_007C, {model[31], model[30]});

    send_pkt(7'h40, 8'h00, 7'h00, 8, 32'hBAD1_0000, 1'b0);
    send_pkt(7'h4A, 8'h05, 7'h00, 8, 32'hBAD2_0000, 1'b0);
    wb_access("wb_write", 32'h0, 1'b1, 32'h0);
    read_all("wb_after_drop");
    check_csr("done_held", 14'h0000, 32'h2);
    csr_write(14'h0000, 32'h2);
    check_csr("done_cleared", 14'h0000, 32'h0);

    // Split completion, with back-pressure on the request
    push_mrd(32'h0, 32'hcacacaca);
    csr_write(14'h0000, 32'h1);
    drain_tx("tx_drain_bp", 1'b1);
    send_pkt(7'h4A, 8'h00, 7'h00, 16, 32'h100, 1'b1);
    check_csr("split_half_busy", 14'h0000, 32'h1);
    send_pkt(7'h4A, 8'h00, 7'h40, 16, 32'h110, 1'b1);
    check_csr("split_done", 14'h0000, 32'h2);
    read_all("wb_split");

    // 4DW request, then reset in the middle of the completion
    csr_write(14'h0002, 32'h1234_5678);
    csr_write(14'h0001, 32'h0000_10FF);
    push_mrd(32'h1234_5678, 32'h0000_10FF);
    csr_write(14'h0000, 32'h3);
    drain_tx("tx_drain_4dw", 1'b0);
    send_pkt(7'h4A, 8'h00, 7'h00, 8, 32'h300, 1'b1);
    check_csr("partial_busy", 14'h0000, 32'h1);
    trn_reset_n = 1'b0;
    repeat (2) tick();
    trn_reset_n = 1'b1;
    tick();
    check_csr("abort_ctrl", 14'h0000, 32'h0);
    check_csr("abort_addr_lo", 14'h0001, 32'h0);
    check_csr("abort_addr_hi", 14'h0002, 32'h0);
    read_all("wb_partial");

    check("tx_q_empty", 64'(tx_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
